// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: op codes, default latencies and the arithmetic result payload.
package e_mdu_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned MUL_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF = 10;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
        logic            div_zero;
    } arith_res_t;

    // True for the four ops that open a busy window.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op >= 4'(MDU_MULT)) && (op <= 4'(MDU_DIVU));
    endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational mult/multu/div/divu datapath producing {hi,lo} and a divide-by-zero flag.
module e_mdu_arith
    import e_mdu_pkg::*;
(
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output arith_res_t      res
);

    logic signed [2*XLEN-1:0] sa;
    logic signed [2*XLEN-1:0] sb;
    logic signed [2*XLEN-1:0] prod_s;
    logic        [2*XLEN-1:0] prod_u;

    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] b_safe;
    logic [XLEN-1:0] q_mag;
    logic [XLEN-1:0] r_mag;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;

    always_comb begin
        sa     = {{XLEN{a[XLEN-1]}}, a};
        sb     = {{XLEN{b[XLEN-1]}}, b};
        prod_s = sa * sb;
        prod_u = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    end

    // Signed division on magnitudes: quotient truncates toward zero, remainder takes dividend sign.
    always_comb begin
        is_signed = (op == 4'(MDU_DIV));
        a_neg     = is_signed & a[XLEN-1];
        b_neg     = is_signed & b[XLEN-1];
        a_mag     = a_neg ? (XLEN'(0) - a) : a;
        b_mag     = b_neg ? (XLEN'(0) - b) : b;
        b_safe    = (b_mag == '0) ? XLEN'(1) : b_mag;
        q_mag     = a_mag / b_safe;
        r_mag     = a_mag % b_safe;
        quot      = (a_neg ^ b_neg) ? (XLEN'(0) - q_mag) : q_mag;
        rem       = a_neg ? (XLEN'(0) - r_mag) : r_mag;
    end

    always_comb begin
        res = '0;
        case (op)
            4'(MDU_MULT): begin
                res.hi = prod_s[2*XLEN-1:XLEN];
                res.lo = prod_s[XLEN-1:0];
            end
            4'(MDU_MULTU): begin
                res.hi = prod_u[2*XLEN-1:XLEN];
                res.lo = prod_u[XLEN-1:0];
            end
            4'(MDU_DIV), 4'(MDU_DIVU): begin
                res.hi       = rem;
                res.lo       = quot;
                res.div_zero = (b == '0);
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide scheduler: fixed-latency busy window, HI/LO commit and D-stage stall request.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      E_MDUOp,
    input  logic [XLEN-1:0] E_A,
    input  logic [XLEN-1:0] E_B,
    input  logic            D_isMDU,
    output logic [XLEN-1:0] E_MDUout,
    output logic            busy,
    output logic            start,
    output logic            stall_req
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [XLEN-1:0]  hi_q,     hi_d;
    logic [XLEN-1:0]  lo_q,     lo_d;
    logic [XLEN-1:0]  hi_tmp_q, hi_tmp_d;
    logic [XLEN-1:0]  lo_tmp_q, lo_tmp_d;
    logic             dz_q,     dz_d;
    mdu_state_e       state;
    arith_res_t       res;

    e_mdu_arith u_arith (
        .op  (E_MDUOp),
        .a   (E_A),
        .b   (E_B),
        .res (res)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_tmp_q <= '0;
            lo_tmp_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
            dz_q     <= dz_d;
        end
    end

    // Ops arriving in RUN are dropped; the pipeline stall keeps them from reaching here.
    always_comb begin
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        dz_d     = dz_q;
        state    = (cnt_q != '0) ? ST_RUN : ST_IDLE;

        case (state)
            ST_IDLE: begin
                if (is_muldiv(E_MDUOp)) begin
                    hi_tmp_d = res.hi;
                    lo_tmp_d = res.lo;
                    dz_d     = res.div_zero;
                    cnt_d    = (E_MDUOp <= 4'(MDU_MULTU)) ? CNT_W'(MUL_CYCLES)
                                                          : CNT_W'(DIV_CYCLES);
                end else if (E_MDUOp == 4'(MDU_MTHI)) begin
                    hi_d = E_A;
                end else if (E_MDUOp == 4'(MDU_MTLO)) begin
                    lo_d = E_A;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if ((cnt_q == CNT_W'(1)) && !dz_q) begin
                    hi_d = hi_tmp_q;
                    lo_d = lo_tmp_q;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_comb begin
        busy      = (cnt_q != '0);
        start     = is_muldiv(E_MDUOp);
        stall_req = D_isMDU & (busy | start);
        case (E_MDUOp)
            4'(MDU_MFHI): E_MDUout = hi_q;
            4'(MDU_MFLO): E_MDUout = lo_q;
            default:      E_MDUout = '0;
        endcase
    end

endmodule

// File: doc/e_mdu.md
# e_mdu

Multi-cycle multiply/divide scheduler for the E stage of the five-stage MIPS pipeline. Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E-stage decode, runs a fixed-latency busy window per operation, commits results to the HI/LO registers at the end of that window, and raises a stall request to the hazard unit while any MDU-class instruction in D would race an active operation.

## Interface

Parameters:
- MUL_CYCLES, 5, busy length of mult/multu
- DIV_CYCLES, 10, busy length of div/divu

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- E_MDUOp  in  4  E-stage operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; other codes = none
- E_A  in  32  rs operand, forwarded
- E_B  in  32  rt operand, forwarded
- D_isMDU  in  1  D-stage instruction is any MDU-class op (codes 1-8)
- E_MDUout  out  32  HI for mfhi, LO for mflo, else 0
- busy  out  1  operation in flight
- start  out  1  E_MDUOp is 1-4 this cycle (combinational)
- stall_req  out  1  D_isMDU & (busy | start)

## Operation

- States: IDLE (cnt = 0), RUN (cnt != 0); busy = (cnt != 0).
- IDLE and E_MDUOp in 1-4: at the edge, latch computed result into hi_tmp/lo_tmp, load cnt with MUL_CYCLES (1,2) or DIV_CYCLES (3,4), and latch div-by-zero flag.
- RUN: cnt decrements each edge; at the edge where cnt == 1, HI <= hi_tmp, LO <= lo_tmp (skipped when div-by-zero flag set), cnt -> 0.
- mthi/mtlo in IDLE: HI <= E_A or LO <= E_A at the edge.
- mfhi/mflo: E_MDUout = HI/LO combinationally; a read in the same cycle as a commit edge returns the old value.
- Any op 1-8 arriving while busy is illegal (pipeline stalls prevent it): it is ignored, state unchanged; the bench flags it as an assertion failure.
- Arithmetic: mult signed 32x32 -> {HI,LO} 64-bit; multu unsigned. div signed: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend; divu unsigned. 0x80000000 / 0xFFFFFFFF signed: LO = 0x80000000, HI = 0.
- Div by zero: busy window still runs full DIV_CYCLES; HI/LO unchanged.
- Reset (any time, including mid-RUN): cnt = 0, HI = LO = 0, hi_tmp = lo_tmp = 0, flag = 0; in-flight result discarded.

## Timing

- Reset values: busy 0, E_MDUout 0, HI 0, LO 0; start and stall_req follow inputs.
- Start sampled at edge N; busy high in the MUL_CYCLES (DIV_CYCLES) cycles following N; HI/LO show the new value in the first cycle busy is low.
- stall_req high in the start cycle and throughout busy whenever D_isMDU; it drops in the same cycle busy drops, so a dependent mfhi in D enters E the cycle the committed value is visible.
- A new start is accepted in the first cycle after busy falls (back-to-back, no bubble).
- mthi/mtlo: one-edge latency, no busy.

## Structure

- Shared header mdu_defs: op-code defines (MDU_NONE ... MDU_MTLO) used by the decoder and this block; MUL_CYCLES/DIV_CYCLES defaults.
- Sub-module e_mdu_arith: combinational, takes op, E_A, E_B; returns 64-bit {hi,lo} and div-by-zero flag. e_mdu holds the counter, HI/LO, tmp registers and stall logic.

## Test plan

- Reset mid-operation: start div, drop reset at busy cycle 4 -> busy 0, HI = LO = 0 immediately; the later mfhi reads 0.
- mult 0xFFFFFFFF x 2 -> busy 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFE; multu same operands -> HI = 1, LO = 0xFFFFFFFE.
- div -7 / 2 -> busy 10 cycles; LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1); divu 7 / 2 -> LO 3, HI 1.
- Div by zero after mthi 0x1234 / mtlo 0x5678 -> busy 10 cycles, HI = 0x1234, LO = 0x5678 unchanged.
- mult in E with mflo in D -> stall_req high for the start cycle plus 5 busy cycles; mflo then reads the product; a second mult issued the cycle busy falls starts without a bubble.
- Illegal mtlo injected while busy -> LO unchanged and the assertion fires.
